// File: rtl/fifo.sv
// Single-clock byte FIFO with registered read data, occupancy status and
// one-cycle overflow/underflow pulses for detecting producer/consumer misuse.
module fifo #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned ALMOST_FULL_TH  = DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY_TH = 1,
    localparam int unsigned ADDR_WIDTH     = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  WEN,
    input  logic                  REN,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Full,
    output logic                  Empty,
    output logic                  AlmostFull,
    output logic                  AlmostEmpty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam logic [ADDR_WIDTH:0] CountMax = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_ok;
    logic                  rd_ok;

    // Status flags derive from the registered count only.
    always_comb begin
        Full        = (count_q == CountMax);
        Empty       = (count_q == '0);
        AlmostFull  = (32'(count_q) >= ALMOST_FULL_TH);
        AlmostEmpty = (32'(count_q) <= ALMOST_EMPTY_TH);
        Count       = count_q;
        ReadData    = rdata_q;
        Overflow    = ovf_q;
        Underflow   = unf_q;
    end

    // Accept decisions and next-state; a full FIFO still takes a write when a pop frees a slot.
    always_comb begin
        wr_ok   = WEN && (!Full || REN);
        rd_ok   = REN && !Empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = rdata_q;
        ovf_d   = WEN && !wr_ok;
        unf_d   = REN && !rd_ok;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d  = rptr_q + 1'b1;
            rdata_d = mem[rptr_q];
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state with synchronous reset taking priority over WEN/REN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array is never cleared; stale entries are unreachable after reset.
    always_ff @(posedge CLK) begin
        if (!RST && wr_ok) begin
            mem[wptr_q] <= WriteData;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFT   = DEPTH - 1;
    localparam int unsigned AET   = 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] WriteData = '0;
    logic          WEN = 1'b0;
    logic          REN = 1'b0;
    logic [DW-1:0] ReadData;
    logic          Full, Empty, AlmostFull, AlmostEmpty;
    logic [3:0]    Count;
    logic          Overflow, Underflow;

    fifo #(
        .DATA_WIDTH      (DW),
        .DEPTH           (DEPTH),
        .ALMOST_FULL_TH  (AFT),
        .ALMOST_EMPTY_TH (AET)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WriteData   (WriteData),
        .WEN         (WEN),
        .REN         (REN),
        .ReadData    (ReadData),
        .Full        (Full),
        .Empty       (Empty),
        .AlmostFull  (AlmostFull),
        .AlmostEmpty (AlmostEmpty),
        .Count       (Count),
        .Overflow    (Overflow),
        .Underflow   (Underflow)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rdata = '0;
    bit            m_ovf = 0;
    bit            m_unf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model of one clock edge, using the occupancy before the edge.
    task automatic model_edge(input bit rst, input bit wen, input bit ren, input logic [DW-1:0] wd);
        int unsigned n;
        bit wr, rd;
        if (rst) begin
            m_q.delete();
            m_rdata = '0;
            m_ovf   = 0;
            m_unf   = 0;
        end else begin
            n  = m_q.size();
            wr = wen && ((n < DEPTH) || ren);
            rd = ren && (n > 0);
            if (rd) m_rdata = m_q.pop_front();
            if (wr) m_q.push_back(wd);
            m_ovf = wen && !wr;
            m_unf = ren && !rd;
        end
    endtask

    task automatic compare_all();
        int unsigned n;
        n = m_q.size();
        check("ReadData", 32'(ReadData), 32'(m_rdata));
        check("Count", 32'(Count), n);
        check("Full", 32'(Full), 32'(n == DEPTH));
        check("Empty", 32'(Empty), 32'(n == 0));
        check("AlmostFull", 32'(AlmostFull), 32'(n >= AFT));
        check("AlmostEmpty", 32'(AlmostEmpty), 32'(n <= AET));
        check("Overflow", 32'(Overflow), 32'(m_ovf));
        check("Underflow", 32'(Underflow), 32'(m_unf));
    endtask

    task automatic step(input bit rst, input bit wen, input bit ren, input logic [DW-1:0] wd);
        @(negedge CLK);
        RST       = rst;
        WEN       = wen;
        REN       = ren;
        WriteData = wd;
        @(posedge CLK);
        model_edge(rst, wen, ren, wd);
        #1;
        compare_all();
    endtask

    logic [DW-1:0] fill_pat [8];

    initial begin
        fill_pat[0] = 8'hF0; fill_pat[1] = 8'h0F; fill_pat[2] = 8'hCC; fill_pat[3] = 8'h33;
        fill_pat[4] = 8'hFF; fill_pat[5] = 8'h66; fill_pat[6] = 8'h00; fill_pat[7] = 8'h99;

        // Reset then idle
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check("reset_readdata", 32'(ReadData), 32'h00);

        // Fill, then overflow attempt
        for (int i = 0; i < 8; i++) step(0, 1, 0, fill_pat[i]);
        check("fill_full", 32'(Full), 32'd1);
        step(0, 1, 0, 8'hAA);
        check("ovf_pulse", 32'(Overflow), 32'd1);
        step(0, 0, 0, 8'h00);
        check("ovf_one_cycle", 32'(Overflow), 32'd0);

        // Drain in order, then underflow attempt
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 8'h00);
            check("drain_order", 32'(ReadData), 32'(fill_pat[i]));
        end
        step(0, 0, 1, 8'h00);
        check("unf_hold", 32'(ReadData), 32'h99);

        // Wrap with concurrent push/pop
        step(0, 1, 0, 8'hD0);
        step(0, 1, 1, 8'h0D);
        check("concurrent_rd", 32'(ReadData), 32'hD0);
        step(0, 0, 1, 8'h00);
        check("wrap_rd", 32'(ReadData), 32'h0D);

        // Simultaneous on empty: write kept, underflow pulses
        step(0, 1, 1, 8'h5C);
        check("empty_both_count", 32'(Count), 32'd1);
        step(0, 0, 1, 8'h00);
        check("empty_both_data", 32'(ReadData), 32'h5C);

        // Simultaneous on full
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h10 + 8'(i));
        step(0, 1, 1, 8'hE7);
        check("full_both_count", 32'(Count), 32'd8);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);
        check("full_both_last", 32'(ReadData), 32'hE7);

        // Reset mid-fill
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h40 + 8'(i));
        step(1, 1, 1, 8'hEE);
        step(0, 1, 0, 8'h5A);
        step(0, 0, 1, 8'h00);
        check("post_reset_rd", 32'(ReadData), 32'h5A);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 127) == 0), ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 50), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
